// File: rtl/gf_pkg.sv
// Shared GF(2^4) definitions: field polynomial, element type and inverter FSM states.
package gf_pkg;

  typedef logic [3:0] gf4_t;

  // Low terms of x^4 + x + 1, folded back in whenever a product overflows bit 3.
  localparam gf4_t GF4_POLY = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    SQ1,
    MUL2,
    SQ3,
    SQ4,
    MUL5,
    DONE
  } gf4_inv_state_t;

endpackage

// File: rtl/FFMul_K4_Q2.sv
// Combinational GF(2^4) multiplier, reduction by gf_pkg::GF4_POLY.
module FFMul_K4_Q2
  import gf_pkg::*;
(
  input  gf4_t i_a,
  input  gf4_t i_b,
  output gf4_t o_p
);

  // Shift-and-add over the bits of i_a, reducing the shifted multiplicand each step.
  always_comb begin
    gf4_t w_acc;
    gf4_t w_sh;
    w_acc = '0;
    w_sh  = i_b;
    for (int i = 0; i < 4; i++) begin
      if (i_a[i]) w_acc = w_acc ^ w_sh;
      w_sh = {w_sh[2:0], 1'b0} ^ ({4{w_sh[3]}} & GF4_POLY);
    end
    o_p = w_acc;
  end

endmodule

// File: rtl/gf4_inv_seq.sv
// Multi-cycle GF(2^4) inverter: a^-1 = a^14 via a 5-multiply addition chain on one multiplier.
// Optional zero-operand flag output enabled by defining GF4_INV_ZERO_FLAG_EN.
module gf4_inv_seq
  import gf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready
`ifdef GF4_INV_ZERO_FLAG_EN
  ,
  output logic       out_zero
`endif
);

  gf4_inv_state_t r_state;
  gf4_t           r_op;
  gf4_t           r_a2;
  gf4_t           r_t;
  gf4_t           r_out_data;
  logic           r_in_ready;
  logic           r_out_valid;

  gf4_t           w_mul_a;
  gf4_t           w_mul_b;
  gf4_t           w_prod;

  // Operand selection depends on state alone, so no input reaches the outputs combinationally.
  always_comb begin
    w_mul_a = r_op;
    w_mul_b = r_op;
    case (r_state)
      MUL2: begin
        w_mul_a = r_t;
        w_mul_b = r_op;
      end
      SQ3, SQ4: begin
        w_mul_a = r_t;
        w_mul_b = r_t;
      end
      MUL5: begin
        w_mul_a = r_t;
        w_mul_b = r_a2;
      end
      default: begin
        w_mul_a = r_op;
        w_mul_b = r_op;
      end
    endcase
  end

  FFMul_K4_Q2 u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_a2        <= '0;
      r_t         <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op       <= in_data;
            r_in_ready <= 1'b0;
            r_state    <= SQ1;
          end
        end
        SQ1: begin
          r_t     <= w_prod;
          r_a2    <= w_prod;
          r_state <= MUL2;
        end
        MUL2: begin
          r_t     <= w_prod;
          r_state <= SQ3;
        end
        SQ3: begin
          r_t     <= w_prod;
          r_state <= SQ4;
        end
        SQ4: begin
          r_t     <= w_prod;
          r_state <= MUL5;
        end
        MUL5: begin
          r_out_data  <= w_prod;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef GF4_INV_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_zero <= (in_data == 4'h0);
    end
  end

  assign out_zero = r_zero;
`endif

endmodule

// File: tb/tb_gf4_inv_seq.sv
// Self-checking bench for gf4_inv_seq: behavioural inverse/timing model plus directed and random ops.
module tb_gf4_inv_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
`ifdef GF4_INV_ZERO_FLAG_EN
  logic       out_zero;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  gf4_inv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef GF4_INV_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: carry-less product of two polynomials, then long division by x^4+x+1.
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    for (int d = 6; d >= 4; d--) if (p[d]) p = p ^ (7'b0010011 << (d - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] ref_inv(input logic [3:0] a);
    for (int b = 1; b < 16; b++) if (ref_mul(a, 4'(b)) == 4'h1) return 4'(b);
    return 4'h0;
  endfunction

  // Model: result appears 5 edges after acceptance and is held until taken.
  logic       m_pending;
  int         m_age;
  logic [3:0] m_res;
  logic [3:0] m_last;
  logic       m_zero;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_age     <= 0;
      m_res     <= 4'h0;
      m_last    <= 4'h0;
      m_zero    <= 1'b0;
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending <= 1'b1;
        m_age     <= 0;
        m_res     <= ref_inv(in_data);
        m_zero    <= (in_data == 4'h0);
      end
    end else if (m_age < 5) begin
      m_age <= m_age + 1;
    end else if (out_ready) begin
      m_pending <= 1'b0;
      m_last    <= m_res;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_valid;
      exp_valid = m_pending && (m_age == 5);
      chk("mon_in_ready", 32'(in_ready), 32'(!m_pending));
      chk("mon_out_valid", 32'(out_valid), 32'(exp_valid));
      chk("mon_out_data", 32'(out_data), 32'(exp_valid ? m_res : m_last));
`ifdef GF4_INV_ZERO_FLAG_EN
      if (exp_valid) chk("mon_out_zero", 32'(out_zero), 32'(m_zero));
`endif
    end
  end

  // One operation; called and returns aligned to a falling edge.
  task automatic do_op(input logic [3:0] a, input logic [3:0] exp, input int stall, input bit noise);
    int  n;
    bit  seen;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = out_valid;
      if (!seen) begin
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        in_valid = noise ? 1'($urandom) : 1'b0;
        in_data  = 4'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'd5);
    chk("result", 32'(out_data), 32'(exp));
    if (a != 4'h0) chk("round_trip", 32'(ref_mul(a, out_data)), 32'd1);
`ifdef GF4_INV_ZERO_FLAG_EN
    chk("out_zero", 32'(out_zero), 32'(a == 4'h0));
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = noise ? 1'($urandom) : 1'b0;
      in_data  = 4'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(exp));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_xfer_valid", 32'(out_valid), 32'd0);
    chk("post_xfer_ready", 32'(in_ready), 32'd1);
    chk("post_xfer_data", 32'(out_data), 32'(exp));
  endtask

  logic [3:0] golden [16] = '{4'd0, 4'd1, 4'd9, 4'd14, 4'd13, 4'd11, 4'd7, 4'd6,
                              4'd15, 4'd2, 4'd12, 4'd5, 4'd10, 4'd4, 4'd3, 4'd8};

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int order [16];

    for (int i = 0; i < 16; i++) chk("model_inv", 32'(ref_inv(4'(i))), 32'(golden[i]));

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    mon_en = 1'b1;

    do_op(4'd2, 4'd9, 0, 1'b0);
    do_op(4'd3, 4'd14, 0, 1'b0);
    do_op(4'd4, 4'd13, 0, 1'b0);
    do_op(4'd15, 4'd8, 0, 1'b1);
    do_op(4'd8, 4'd15, 0, 1'b1);
    do_op(4'd1, 4'd1, 0, 1'b1);
    do_op(4'd0, 4'd0, 0, 1'b0);
    do_op(4'd5, 4'd11, 0, 1'b0);
    do_op(4'd6, 4'd7, 10, 1'b1);

    // Abort a chain while it is squaring a^3.
    in_valid = 1'b1;
    in_data  = 4'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midreset_no_valid", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j;
      int tmp;
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      do_op(4'(order[i]), golden[order[i]], int'($urandom_range(3, 0)), 1'b1);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
